// File: rtl/ssaver_motion_ctrl.sv
// Frame-synchronous screen-saver ball motion controller: moves and bounces the ball during vertical blanking.
// Optional colour stepping on bounce is enabled by defining SSAVER_COLOR_CYCLE_EN.
module ssaver_motion_ctrl #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned RADIUS    = 10,
  parameter int unsigned START_X   = 100,
  parameter int unsigned START_Y   = 100,
  parameter int unsigned FRAME_DIV = 1
) (
  input  logic       clock25MHz,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       run,
  input  logic       step,
  input  logic [2:0] speed,
  output logic [9:0] ballX,
  output logic [9:0] ballY,
  output logic       dirX,
  output logic       dirY,
  output logic [2:0] colorIdx,
  output logic       bounce,
  output logic       busy
);

  localparam int unsigned PW  = 11;
  localparam int unsigned CW  = 8;
  localparam logic [PW-1:0] XMIN     = PW'(RADIUS);
  localparam logic [PW-1:0] XMAX     = PW'(H_ACTIVE - 1 - RADIUS);
  localparam logic [PW-1:0] YMIN     = PW'(RADIUS);
  localparam logic [PW-1:0] YMAX     = PW'(V_ACTIVE - 1 - RADIUS);
  localparam logic [CW-1:0] DIV_LAST = CW'(FRAME_DIV - 1);
  localparam logic [9:0]    V_TICK   = 10'(V_ACTIVE);

  typedef enum logic [1:0] {IDLE, UPD_X, UPD_Y} state_t;

  state_t        state, state_d;
  logic [CW-1:0] fcnt;
  logic          step_pend;
  logic [2:0]    spd_q, spd_d;
  logic          hitx_q, hitx_d, hity_c;
  logic [9:0]    ballx_d, bally_d;
  logic          dirx_d, diry_d, bounce_d, busy_d;
  logic [2:0]    color_d;
  logic          frame_tick_c, move_due_c;

  assign frame_tick_c = (x == 10'd0) && (y == V_TICK);
  assign move_due_c   = frame_tick_c && (step_pend || (run && (fcnt == DIV_LAST)));

  // Reflecting one-axis step; result packs {hit, new_dir, new_pos}.
  function automatic logic [11:0] axis_move(input logic [9:0] pos, input logic dir,
                                            input logic [2:0] spd, input logic [PW-1:0] lo,
                                            input logic [PW-1:0] hi);
    logic [PW-1:0] p;
    logic [PW-1:0] s;
    logic [11:0]   r;
    p = {1'b0, pos};
    s = PW'(spd);
    r = {1'b0, dir, pos};
    if (spd != 3'd0) begin
      if (dir) begin
        if ((p + s) >= hi) r = {1'b1, 1'b0, hi[9:0]};
        else               r = {1'b0, 1'b1, 10'(p + s)};
      end else begin
        if (p <= (lo + s)) r = {1'b1, 1'b1, lo[9:0]};
        else               r = {1'b0, 1'b0, 10'(p - s)};
      end
    end
    return r;
  endfunction

  // Frame divider and paused single-step latch.
  always_ff @(posedge clock25MHz or negedge reset) begin
    if (!reset) begin
      fcnt      <= '0;
      step_pend <= 1'b0;
    end else begin
      if (!run)              fcnt <= '0;
      else if (frame_tick_c) fcnt <= (fcnt == DIV_LAST) ? '0 : fcnt + CW'(1);
      step_pend <= (step && !run) || (step_pend && !frame_tick_c);
    end
  end

  always_ff @(posedge clock25MHz or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      spd_q    <= '0;
      hitx_q   <= 1'b0;
      ballX    <= 10'(START_X);
      ballY    <= 10'(START_Y);
      dirX     <= 1'b1;
      dirY     <= 1'b1;
      colorIdx <= 3'd7;
      bounce   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      spd_q    <= spd_d;
      hitx_q   <= hitx_d;
      ballX    <= ballx_d;
      ballY    <= bally_d;
      dirX     <= dirx_d;
      dirY     <= diry_d;
      colorIdx <= color_d;
      bounce   <= bounce_d;
      busy     <= busy_d;
    end
  end

  always_comb begin
    state_d  = state;
    spd_d    = spd_q;
    hitx_d   = hitx_q;
    hity_c   = 1'b0;
    ballx_d  = ballX;
    bally_d  = ballY;
    dirx_d   = dirX;
    diry_d   = dirY;
    color_d  = colorIdx;
    bounce_d = 1'b0;
    case (state)
      IDLE: begin
        hitx_d = 1'b0;
        if (move_due_c) state_d = UPD_X;
      end
      UPD_X: begin
        spd_d = speed;
        {hitx_d, dirx_d, ballx_d} = axis_move(ballX, dirX, speed, XMIN, XMAX);
        state_d = UPD_Y;
      end
      UPD_Y: begin
        {hity_c, diry_d, bally_d} = axis_move(ballY, dirY, spd_q, YMIN, YMAX);
        // A corner hit counts as a single bounce event.
        bounce_d = hitx_q || hity_c;
`ifdef SSAVER_COLOR_CYCLE_EN
        if (bounce_d) color_d = colorIdx + 3'd1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_ssaver_motion_ctrl.sv
// Directed self-checking bench for ssaver_motion_ctrl; four instances cover centre motion,
// right-edge bounce, corner bounce and the frame divider, each held in reset when idle.
module tb_ssaver_motion_ctrl;

`ifdef SSAVER_COLOR_CYCLE_EN
  localparam int COLOR_AFTER1 = 0;
`else
  localparam int COLOR_AFTER1 = 7;
`endif

  logic       clock25MHz = 1'b0;
  logic [3:0] rst_n;
  logic [9:0] x, y;
  logic       run, step;
  logic [2:0] speed;
  logic [9:0] bx [4];
  logic [9:0] by [4];
  logic       dx [4];
  logic       dy [4];
  logic [2:0] ci [4];
  logic       bnc [4];
  logic       bsy [4];

  int cnt_run  = 0;
  int cnt_fail = 0;

  always #20 clock25MHz = ~clock25MHz;

  ssaver_motion_ctrl u0 (
    .clock25MHz(clock25MHz), .reset(rst_n[0]), .x(x), .y(y), .run(run), .step(step), .speed(speed),
    .ballX(bx[0]), .ballY(by[0]), .dirX(dx[0]), .dirY(dy[0]), .colorIdx(ci[0]), .bounce(bnc[0]), .busy(bsy[0]));

  ssaver_motion_ctrl #(.START_X(627)) u1 (
    .clock25MHz(clock25MHz), .reset(rst_n[1]), .x(x), .y(y), .run(run), .step(step), .speed(speed),
    .ballX(bx[1]), .ballY(by[1]), .dirX(dx[1]), .dirY(dy[1]), .colorIdx(ci[1]), .bounce(bnc[1]), .busy(bsy[1]));

  ssaver_motion_ctrl #(.START_X(627), .START_Y(467)) u2 (
    .clock25MHz(clock25MHz), .reset(rst_n[2]), .x(x), .y(y), .run(run), .step(step), .speed(speed),
    .ballX(bx[2]), .ballY(by[2]), .dirX(dx[2]), .dirY(dy[2]), .colorIdx(ci[2]), .bounce(bnc[2]), .busy(bsy[2]));

  ssaver_motion_ctrl #(.FRAME_DIV(3)) u3 (
    .clock25MHz(clock25MHz), .reset(rst_n[3]), .x(x), .y(y), .run(run), .step(step), .speed(speed),
    .ballX(bx[3]), .ballY(by[3]), .dirX(dx[3]), .dirY(dy[3]), .colorIdx(ci[3]), .bounce(bnc[3]), .busy(bsy[3]));

  task automatic check_eq(input string tag, input int got, input int exp);
    cnt_run++;
    if (got != exp) begin
      cnt_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One-cycle frame tick; returns at the first negedge after the tick edge (T+1).
  task automatic tick();
    @(negedge clock25MHz); x = 10'd0; y = 10'd480;
    @(negedge clock25MHz); x = 10'd7; y = 10'd480;
  endtask

  task automatic settle();
    repeat (3) @(negedge clock25MHz);
  endtask

  task automatic pulse_step();
    @(negedge clock25MHz); step = 1'b1;
    @(negedge clock25MHz); step = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    x = 10'd7; y = 10'd480; run = 1'b0; step = 1'b0; speed = 3'd0; rst_n = 4'b0000;
    repeat (3) @(negedge clock25MHz);

    check_eq("rst_ballX", int'(bx[0]), 100);
    check_eq("rst_ballY", int'(by[0]), 100);
    check_eq("rst_dirX", int'(dx[0]), 1);
    check_eq("rst_dirY", int'(dy[0]), 1);
    check_eq("rst_color", int'(ci[0]), 7);
    check_eq("rst_bounce", int'(bnc[0]), 0);
    check_eq("rst_busy", int'(bsy[0]), 0);

    // Free-running, speed 1, one move per frame.
    rst_n[0] = 1'b1; run = 1'b1; speed = 3'd1;
    @(negedge clock25MHz);
    tick();
    check_eq("t1_busy_T1", int'(bsy[0]), 1);
    check_eq("t1_x_T1", int'(bx[0]), 100);
    @(negedge clock25MHz);
    check_eq("t1_x_T2", int'(bx[0]), 101);
    check_eq("t1_y_T2", int'(by[0]), 100);
    check_eq("t1_busy_T2", int'(bsy[0]), 1);
    @(negedge clock25MHz);
    check_eq("t1_y_T3", int'(by[0]), 101);
    check_eq("t1_busy_T3", int'(bsy[0]), 0);
    check_eq("t1_bounce_T3", int'(bnc[0]), 0);
    tick(); settle();
    tick();
    @(negedge clock25MHz);
    speed = 3'd5;
    @(negedge clock25MHz);
    check_eq("t1_x_3f", int'(bx[0]), 103);
    check_eq("t1_y_spd_hold", int'(by[0]), 103);
    speed = 3'd1;
    @(negedge clock25MHz);

    // Paused operation and the step latch.
    run = 1'b0;
    tick(); settle();
    check_eq("pause_no_move", int'(bx[0]), 103);
    pulse_step();
    tick(); settle();
    check_eq("step_x", int'(bx[0]), 104);
    check_eq("step_y", int'(by[0]), 104);
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
    end
    check_eq("step_once", int'(bx[0]), 104);
    run = 1'b1;
    pulse_step();
    tick(); settle();
    check_eq("run_move", int'(bx[0]), 105);
    run = 1'b0;
    tick(); settle();
    check_eq("step_ignored", int'(bx[0]), 105);

    // Right-edge bounce from x=627 at speed 4.
    rst_n[0] = 1'b0; rst_n[1] = 1'b1; run = 1'b1; speed = 3'd4;
    @(negedge clock25MHz);
    tick();
    @(negedge clock25MHz);
    check_eq("edge_x", int'(bx[1]), 629);
    check_eq("edge_dirX", int'(dx[1]), 0);
    check_eq("edge_bounce_T2", int'(bnc[1]), 0);
    @(negedge clock25MHz);
    check_eq("edge_y", int'(by[1]), 104);
    check_eq("edge_bounce_T3", int'(bnc[1]), 1);
    check_eq("edge_color", int'(ci[1]), COLOR_AFTER1);
    @(negedge clock25MHz);
    check_eq("edge_bounce_T4", int'(bnc[1]), 0);
    tick(); settle();
    check_eq("edge_back_x", int'(bx[1]), 625);
    check_eq("edge_back_color", int'(ci[1]), COLOR_AFTER1);
    speed = 3'd0;
    tick(); settle();
    check_eq("frozen_x", int'(bx[1]), 625);
    check_eq("frozen_y", int'(by[1]), 108);

    // Corner hit: both axes reflect, one bounce event.
    rst_n[1] = 1'b0; rst_n[2] = 1'b1; speed = 3'd4;
    @(negedge clock25MHz);
    tick();
    @(negedge clock25MHz);
    check_eq("corner_x", int'(bx[2]), 629);
    check_eq("corner_dirX", int'(dx[2]), 0);
    check_eq("corner_bounce_T2", int'(bnc[2]), 0);
    @(negedge clock25MHz);
    check_eq("corner_y", int'(by[2]), 469);
    check_eq("corner_dirY", int'(dy[2]), 0);
    check_eq("corner_bounce_T3", int'(bnc[2]), 1);
    check_eq("corner_color", int'(ci[2]), COLOR_AFTER1);
    @(negedge clock25MHz);
    check_eq("corner_bounce_T4", int'(bnc[2]), 0);
    check_eq("corner_color_once", int'(ci[2]), COLOR_AFTER1);

    // Reset asserted in the middle of a bouncing update.
    rst_n[2] = 1'b0; rst_n[1] = 1'b1;
    @(negedge clock25MHz);
    tick();
    @(negedge clock25MHz);
    check_eq("midrst_pre_x", int'(bx[1]), 629);
    rst_n[1] = 1'b0;
    #1;
    check_eq("midrst_x", int'(bx[1]), 627);
    check_eq("midrst_y", int'(by[1]), 100);
    check_eq("midrst_busy", int'(bsy[1]), 0);
    check_eq("midrst_color", int'(ci[1]), 7);
    check_eq("midrst_dirX", int'(dx[1]), 1);
    @(negedge clock25MHz);
    check_eq("midrst_bounce", int'(bnc[1]), 0);

    // Frame divider of 3 at speed 2.
    rst_n[3] = 1'b1; run = 1'b1; speed = 3'd2;
    @(negedge clock25MHz);
    tick(); settle();
    tick(); settle();
    check_eq("div_wait", int'(bx[3]), 100);
    tick(); settle();
    check_eq("div_first", int'(bx[3]), 102);
    for (int i = 0; i < 6; i++) begin
      tick(); settle();
    end
    check_eq("div_9ticks", int'(bx[3]), 106);
    tick(); settle();
    run = 1'b0;
    tick(); settle();
    run = 1'b1;
    tick(); settle();
    tick(); settle();
    check_eq("div_hold_clear", int'(bx[3]), 106);
    tick(); settle();
    check_eq("div_after_pause", int'(bx[3]), 108);

    $display("[TB] %0d tests run, %0d failed", cnt_run, cnt_fail);
    $finish;
  end

endmodule

// File: doc/ssaver_motion_ctrl.md
# ssaver_motion_ctrl

Frame-synchronous motion controller for the monitor-tester screen-saver ball. It watches the VGA raster coordinates, detects the start of vertical blanking and advances the ball centre once per configured number of frames. It bounces the ball off the active-area edges and, optionally, steps a colour index on each bounce. Its `ballX`/`ballY` outputs drive the ball renderer, so position changes happen only during blanking and never tear.

## Interface
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines per frame.
- `RADIUS`, 10: ball half-size in pixels.
- `START_X`, 100: reset X centre.
- `START_Y`, 100: reset Y centre.
- `FRAME_DIV`, 1: frames per move while running, 1..255.

- `clock25MHz`  in  1  pixel clock, the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `x`  in  10  current raster column from the VGA timing block.
- `y`  in  10  current raster line from the VGA timing block.
- `run`  in  1  level; 1 = free-running motion, 0 = paused.
- `step`  in  1  one-cycle pulse; requests a single move while paused.
- `speed`  in  3  pixels per move on each axis; 0 = frozen.
- `ballX`  out  10  ball centre X.
- `ballY`  out  10  ball centre Y.
- `dirX`  out  1  1 = moving right.
- `dirY`  out  1  1 = moving down.
- `colorIdx`  out  3  palette index for the renderer.
- `bounce`  out  1  one-cycle pulse when any axis reflects.
- `busy`  out  1  high while in `UPD_X` or `UPD_Y`.

## Operation
- Limits: `XMIN=RADIUS`, `XMAX=H_ACTIVE-1-RADIUS`, `YMIN=RADIUS`, `YMAX=V_ACTIVE-1-RADIUS`.
- All position arithmetic is 11-bit unsigned, so there is no wrap.
- `frame_tick` is a single cycle, asserted when `x==0 && y==V_ACTIVE` (first blanking line).
- Frame counter:
  - Counts ticks 0..FRAME_DIV-1 while `run=1`.
  - A move is due when the counter reaches FRAME_DIV-1, and the counter then returns to 0.
  - Counter is held at 0 while `run=0`.
- Step latch:
  - A `step` pulse while `run=0` sets `step_pend`.
  - The next `frame_tick` makes a move due regardless of the divider and clears `step_pend`.
  - `step` while `run=1` is ignored.
- States: `IDLE` → `UPD_X` → `UPD_Y` → `IDLE`.
  - `IDLE`: waits for `frame_tick` with a move due.
  - `UPD_X`: captures `speed` into `spd_q`, then updates X.
  - `UPD_Y`: updates Y using the same `spd_q`, then returns to `IDLE`.
- Axis update, shown for X (Y is identical with its own limits):
  - `spd_q==0`: no change, no bounce.
  - Moving right, `ballX+spd_q >= XMAX`: `ballX=XMAX`, `dirX` flips, X-bounce recorded.
  - Moving right otherwise: `ballX=ballX+spd_q`.
  - Moving left, `ballX <= XMIN+spd_q`: `ballX=XMIN`, `dirX` flips, X-bounce recorded.
  - Moving left otherwise: `ballX=ballX-spd_q`.
- If either axis bounced during the move, `bounce` pulses once and `colorIdx` increments once, even on a corner hit. `colorIdx` wraps 7→0.
- `run` falling during `UPD_X`/`UPD_Y` does not abort the update in progress.
- Reset values: `ballX=START_X`, `ballY=START_Y`, `dirX=1`, `dirY=1`, `colorIdx=7`, `bounce=0`, `busy=0`, state `IDLE`, frame counter 0, `step_pend=0`.
- Reset asserted mid-update returns every register to its reset value immediately.

## Timing
- Let T be the cycle in which `frame_tick` is sampled with a move due.
- T+1: state is `UPD_X`, `busy=1`.
- T+2: new `ballX`/`dirX` visible, state is `UPD_Y`.
- T+3: new `ballY`/`dirY` visible; `bounce` high for this cycle only; `colorIdx` updated; `busy=0`; state `IDLE`.
- Every output is registered; there is no combinational path from input to output.
- Tick-to-complete latency is 3 cycles, far inside the blanking interval.
- `speed` is sampled only at T+1; a change at T+2 has no effect until the next move.
- A second `frame_tick` cannot occur during `busy`.

## Configuration
- `SSAVER_COLOR_CYCLE_EN` defined: `colorIdx` increments on each bounce event as described.
- `SSAVER_COLOR_CYCLE_EN` undefined:
  - `colorIdx` is constant 7 (white).
  - Increment logic is removed.
  - `bounce` still pulses.

## Test plan
- Reset then `run=1`, `speed=1`, `FRAME_DIV=1`, 3 frames → `ballX=103`, `ballY=103`; each update lands at T+2 / T+3 after its tick.
- Set `ballX` near the right edge (moving right, `ballX=627`), `speed=4`, one move → `ballX=629`, `dirX=0`, `bounce` pulses once, `colorIdx` 7→0.
- Corner hit: `ballX=627`, `ballY=467`, both moving positive, `speed=4` → `ballX=629`, `ballY=469`, single `bounce`, `colorIdx` +1 once.
- `run=0`, then a `step` pulse → exactly one move at the next tick; the following 3 ticks produce no movement; a `step` while `run=1` causes no extra move.
- `FRAME_DIV=3`, `run=1`, `speed=2`, 9 ticks → exactly 3 moves; `ballX` advances by 6.
- Reset asserted at T+2 → `ballX=100`, `ballY=100`, `busy=0`, `colorIdx=7` in the same cycle; no `bounce` pulse.
